icache_direct: RTL and testbench

- Direct-mapped, read-only instruction cache between the core fetch stage (ibus request/response) and the core bus (cbus).
- Hits are answered in the same cycle from a register array.
- Misses run a 4-beat burst refill over cbus, then answer.
- Upstream is the programCounter fetch logic. Downstream is the bus arbiter / memory.

---
 rtl/icache_direct_pkg.sv | 49 ++++
 rtl/icache_refill_fsm.sv | 78 +++++++
 rtl/icache_direct.sv | 165 ++++++++++++++++
 tb/tb_icache_direct.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_direct_pkg.sv
// Shared types for the direct-mapped instruction cache and its cbus port.
// Holds cbus request/response bundles, burst encodings and the refill FSM states.
package icache_direct_pkg;

    localparam int ICACHE_LINE_BYTES = 32;
    localparam int ICACHE_OFF_W = $clog2(ICACHE_LINE_BYTES);
    localparam int LINE_ADDR_W = 64 - ICACHE_OFF_W;

    // cbus length code is beats-1
    typedef enum logic [1:0] {
        CBUS_LEN_1 = 2'd0,
        CBUS_LEN_2 = 2'd1,
        CBUS_LEN_4 = 2'd3
    } cbus_len_e;

    // cbus size code is log2(bytes per beat)
    typedef enum logic [2:0] {
        CBUS_SIZE_1B = 3'd0,
        CBUS_SIZE_2B = 3'd1,
        CBUS_SIZE_4B = 3'd2,
        CBUS_SIZE_8B = 3'd3
    } cbus_size_e;

    typedef enum logic {
        CBUS_BURST_FIXED = 1'b0,
        CBUS_BURST_INCR  = 1'b1
    } cbus_burst_e;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        cbus_len_e   len;
        cbus_size_e  size;
        cbus_burst_e burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REFILL  = 2'd1,
        RESPOND = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/icache_refill_fsm.sv
// Refill controller: state register, beat counter, latched line address, cbus request.
// Ports: clk/rst, ireq_valid+hit (miss detect), req_line (fetch line addr),
//        cresp (beat handshake), creq (bus request), state/beat_cnt/fill_line,
//        miss_start/beat_we/fill_done strobes for the array owner.
module icache_refill_fsm
    import icache_direct_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ireq_valid,
    input  logic                   hit,
    input  logic [LINE_ADDR_W-1:0] req_line,
    input  cbus_resp_t             cresp,
    output cbus_req_t              creq,
    output fsm_state_e             state,
    output logic [1:0]             beat_cnt,
    output logic [LINE_ADDR_W-1:0] fill_line,
    output logic                   miss_start,
    output logic                   beat_we,
    output logic                   fill_done
);

    fsm_state_e state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat_cnt  <= 2'd0;
            fill_line <= '0;
        end else begin
            state <= state_nxt;
            if (miss_start) begin
                fill_line <= req_line;
                beat_cnt  <= 2'd0;
            end else if (beat_we) begin
                beat_cnt <= beat_cnt + 2'd1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        miss_start = 1'b0;
        beat_we    = 1'b0;
        fill_done  = 1'b0;
        // length/size/burst stay driven while idle
        creq.valid = 1'b0;
        creq.addr  = {fill_line, {ICACHE_OFF_W{1'b0}}};
        creq.len   = CBUS_LEN_4;
        creq.size  = CBUS_SIZE_8B;
        creq.burst = CBUS_BURST_INCR;
        unique case (state)
            IDLE: begin
                if (ireq_valid && !hit) begin
                    miss_start = 1'b1;
                    state_nxt  = REFILL;
                end
            end
            REFILL: begin
                creq.valid = 1'b1;
                if (cresp.ready) begin
                    beat_we = 1'b1;
                    if (cresp.last) begin
                        fill_done = 1'b1;
                        state_nxt = RESPOND;
                    end
                end
            end
            RESPOND: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: same-cycle hits, 4-beat burst refill on miss.
// Ports: ireq_* fetch request, iresp_* response, creq_*/cresp_* core bus burst port,
//        flush (only when ICACHE_FLUSH_EN is defined) invalidates every line.
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int NUM_LINES  = 16,
    parameter int LINE_BEATS = 4
) (
    input  logic        clk,
    input  logic        rst,
`ifdef ICACHE_FLUSH_EN
    input  logic        flush,
`endif
    input  logic        ireq_valid,
    input  logic [63:0] ireq_addr,
    output logic        iresp_addr_ok,
    output logic        iresp_data_ok,
    output logic [31:0] iresp_data,
    output logic        creq_valid,
    output logic [63:0] creq_addr,
    output logic [1:0]  creq_len,
    output logic [2:0]  creq_size,
    output logic        creq_burst,
    input  logic        cresp_ready,
    input  logic        cresp_last,
    input  logic [63:0] cresp_data
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 64 - ICACHE_OFF_W - IDX_W;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [1:0]       beat_t;

    logic [NUM_LINES-1:0] valid_q;
    tag_t                 tag_q  [NUM_LINES];
    logic [63:0]          data_q [NUM_LINES][LINE_BEATS];

    logic [LINE_ADDR_W-1:0] req_line;
    logic [LINE_ADDR_W-1:0] fill_line;
    idx_t       req_idx;
    tag_t       req_tag;
    idx_t       fill_idx;
    tag_t       fill_tag;
    idx_t       rd_idx;
    beat_t      rd_beat;
    logic       rd_half;
    logic [63:0] rd_data;
    logic       hit;
    logic       rsp_ok;
    logic       unused_addr;

    cbus_req_t  creq;
    cbus_resp_t cresp;
    fsm_state_e state;
    beat_t      beat_cnt;
    logic       miss_start;
    logic       beat_we;
    logic       fill_done;
    logic       flush_now;

    assign req_line = ireq_addr[63:ICACHE_OFF_W];
    assign req_idx  = req_line[IDX_W-1:0];
    assign req_tag  = req_line[LINE_ADDR_W-1:IDX_W];
    assign fill_idx = fill_line[IDX_W-1:0];
    assign fill_tag = fill_line[LINE_ADDR_W-1:IDX_W];
    assign unused_addr = ^ireq_addr[1:0];

    assign hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    assign cresp.ready = cresp_ready;
    assign cresp.last  = cresp_last;
    assign cresp.data  = cresp_data;

    icache_refill_fsm u_fsm (
        .clk        (clk),
        .rst        (rst),
        .ireq_valid (ireq_valid),
        .hit        (hit),
        .req_line   (req_line),
        .cresp      (cresp),
        .creq       (creq),
        .state      (state),
        .beat_cnt   (beat_cnt),
        .fill_line  (fill_line),
        .miss_start (miss_start),
        .beat_we    (beat_we),
        .fill_done  (fill_done)
    );

    assign creq_valid = creq.valid;
    assign creq_addr  = creq.addr;
    assign creq_len   = creq.len;
    assign creq_size  = creq.size;
    assign creq_burst = creq.burst;

`ifdef ICACHE_FLUSH_EN
    // a flush seen mid-refill is held until the refill has been answered
    logic flush_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_pend <= 1'b0;
        end else if (state == REFILL && flush) begin
            flush_pend <= 1'b1;
        end else if (state == RESPOND) begin
            flush_pend <= 1'b0;
        end
    end

    assign flush_now = (state == IDLE && flush) ||
                       (state == RESPOND && (flush_pend || flush));
`else
    assign flush_now = 1'b0;
`endif

    // victim goes invalid as soon as the refill starts, so partial lines never hit
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            if (miss_start) begin
                valid_q[req_idx] <= 1'b0;
            end
            if (fill_done) begin
                valid_q[fill_idx] <= 1'b1;
            end
            if (flush_now) begin
                valid_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (beat_we) begin
            data_q[fill_idx][beat_cnt] <= cresp_data;
        end
        if (fill_done) begin
            tag_q[fill_idx] <= fill_tag;
        end
    end

    // while answering a refill the latched line is read; beat/half follow the live address
    assign rd_idx  = (state == RESPOND) ? fill_idx : req_idx;
    assign rd_beat = ireq_addr[4:3];
    assign rd_half = ireq_addr[2];
    assign rd_data = data_q[rd_idx][rd_beat];

    always_comb begin
        rsp_ok = 1'b0;
        unique case (state)
            IDLE:    rsp_ok = ireq_valid && hit;
            RESPOND: rsp_ok = 1'b1;
            default: rsp_ok = 1'b0;
        endcase
    end

    assign iresp_addr_ok = rsp_ok;
    assign iresp_data_ok = rsp_ok;
    assign iresp_data    = !rsp_ok ? 32'd0 :
                           rd_half ? rd_data[63:32] : rd_data[31:0];

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct (default 16 lines; flush test when ICACHE_FLUSH_EN).
// Directed fetches against a line-level cache model plus literal pins on latency and data.
module tb_icache_direct;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ireq_valid = 1'b0;
    logic [63:0] ireq_addr = 64'd0;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        creq_valid;
    logic [63:0] creq_addr;
    logic [1:0]  creq_len;
    logic [2:0]  creq_size;
    logic        creq_burst;
    logic        cresp_ready = 1'b0;
    logic        cresp_last = 1'b0;
    logic [63:0] cresp_data = 64'd0;
`ifdef ICACHE_FLUSH_EN
    logic        flush = 1'b0;
`endif

    icache_direct dut (
        .clk           (clk),
        .rst           (rst),
`ifdef ICACHE_FLUSH_EN
        .flush         (flush),
`endif
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .iresp_addr_ok (iresp_addr_ok),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .creq_valid    (creq_valid),
        .creq_addr     (creq_addr),
        .creq_len      (creq_len),
        .creq_size     (creq_size),
        .creq_burst    (creq_burst),
        .cresp_ready   (cresp_ready),
        .cresp_last    (cresp_last),
        .cresp_data    (cresp_data)
    );

    always #5 clk = ~clk;

    // line-level model: 16 lines, tag = addr[63:9], idx = addr[8:5]
    bit          m_valid [16];
    logic [54:0] m_tag   [16];
    logic [63:0] m_data  [16][4];
    logic [63:0] bt      [4];

    // per-cycle expectations driven alongside the stimulus
    bit          chk_en = 1'b0;
    bit          exp_ok = 1'b0;
    logic [31:0] exp_data = 32'd0;
    bit          exp_cv = 1'b0;
    logic [63:0] exp_ca = 64'd0;

    // literal pins queued by the stimulus, checked by the compare process
    string       pin_nm  [32];
    logic [63:0] pin_act [32];
    logic [63:0] pin_exp [32];
    int          pin_wr = 0;
    int          pin_rd = 0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("data_ok", {63'd0, iresp_data_ok}, {63'd0, exp_ok});
            check("addr_ok", {63'd0, iresp_addr_ok}, {63'd0, exp_ok});
            check("data", {32'd0, iresp_data}, {32'd0, exp_data});
            check("creq_valid", {63'd0, creq_valid}, {63'd0, exp_cv});
            if (exp_cv) check("creq_addr", creq_addr, exp_ca);
            check("creq_len", {62'd0, creq_len}, 64'd3);
            check("creq_size", {61'd0, creq_size}, 64'd3);
            check("creq_burst", {63'd0, creq_burst}, 64'd1);
        end
        while (pin_rd < pin_wr) begin
            check(pin_nm[pin_rd], pin_act[pin_rd], pin_exp[pin_rd]);
            pin_rd++;
        end
    end

    task automatic pin(input string nm, input logic [63:0] act, input logic [63:0] exp);
        pin_nm[pin_wr]  = nm;
        pin_act[pin_wr] = act;
        pin_exp[pin_wr] = exp;
        pin_wr++;
    endtask

    // a burst must carry exactly four beats
    int tb_beats = 0;
    always @(posedge clk) begin
        if (rst) begin
            tb_beats = 0;
        end else if (creq_valid && cresp_ready) begin
            if (cresp_last) begin
                assert (tb_beats == 3) else $error("burst ended after %0d beats", tb_beats + 1);
                tb_beats = 0;
            end else begin
                tb_beats++;
            end
        end
    end

    function automatic bit m_hit(input logic [63:0] a);
        return m_valid[a[8:5]] && (m_tag[a[8:5]] == a[63:9]);
    endfunction

    function automatic logic [31:0] m_word(input logic [63:0] a);
        logic [63:0] b;
        b = m_data[a[8:5]][a[4:3]];
        return a[2] ? b[63:32] : b[31:0];
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    task automatic set_beats(input logic [63:0] b0, input logic [63:0] b1,
                             input logic [63:0] b2, input logic [63:0] b3);
        bt[0] = b0;
        bt[1] = b1;
        bt[2] = b2;
        bt[3] = b3;
    endtask

    task automatic idle_exp();
        exp_ok   = 1'b0;
        exp_data = 32'd0;
        exp_cv   = 1'b0;
    endtask

    // one fetch; on a miss pat[c] gives cresp_ready for refill cycle c
    // lat = cycles from request to first data_ok (-1 if none), word = data seen then
    task automatic fetch(input logic [63:0] a, input logic [15:0] pat, input int plen,
                         output int lat, output logic [31:0] word);
        int n;
        lat  = -1;
        word = 32'd0;
        ireq_valid = 1'b1;
        ireq_addr  = a;
        if (m_hit(a)) begin
            exp_ok   = 1'b1;
            exp_data = m_word(a);
            exp_cv   = 1'b0;
            @(negedge clk);
            if (iresp_data_ok) begin
                lat  = 0;
                word = iresp_data;
            end
            @(posedge clk); #1;
        end else begin
            idle_exp();
            @(negedge clk);
            @(posedge clk); #1;
            n = 0;
            for (int c = 0; c < plen; c++) begin
                cresp_ready = pat[c];
                cresp_last  = pat[c] && (n == 3);
                cresp_data  = pat[c] ? bt[n] : 64'hdead_beef_dead_beef;
                exp_cv = 1'b1;
                exp_ca = {a[63:5], 5'd0};
                @(negedge clk);
                if (iresp_data_ok && lat < 0) lat = c + 1;
                @(posedge clk); #1;
                if (pat[c]) n++;
            end
            cresp_ready = 1'b0;
            cresp_last  = 1'b0;
            m_valid[a[8:5]] = 1'b1;
            m_tag[a[8:5]]   = a[63:9];
            for (int k = 0; k < 4; k++) m_data[a[8:5]][k] = bt[k];
            exp_ok   = 1'b1;
            exp_data = m_word(a);
            exp_cv   = 1'b0;
            @(negedge clk);
            if (iresp_data_ok && lat < 0) begin
                lat  = plen + 1;
                word = iresp_data;
            end
            @(posedge clk); #1;
        end
        ireq_valid = 1'b0;
        idle_exp();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    int          lat;
    logic [31:0] word;

    initial begin
        m_clear();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_exp();
        chk_en = 1'b1;
        @(negedge clk);
        pin("reset_creq_valid", {63'd0, creq_valid}, 64'd0);
        pin("reset_data_ok", {63'd0, iresp_data_ok}, 64'd0);
        @(posedge clk); #1;

        // cold miss, straight 4-beat burst
        set_beats(64'h0000_0014_0000_0011, 64'h0000_0024_0000_0022,
                  64'h0000_0034_0000_0033, 64'h0000_0044_0000_0043);
        fetch(64'h8000_0000, 16'h000f, 4, lat, word);
        pin("cold_latency", lat, 64'd5);
        pin("cold_word", {32'd0, word}, 64'h11);

        // hits on the filled line
        fetch(64'h8000_001c, 16'h000f, 4, lat, word);
        pin("hit_latency", lat, 64'd0);
        pin("hit_word_b3_hi", {32'd0, word}, 64'h44);
        fetch(64'h8000_0008, 16'h000f, 4, lat, word);
        pin("hit_word_b1_lo", {32'd0, word}, 64'h22);
        fetch(64'h8000_0014, 16'h000f, 4, lat, word);
        pin("hit_word_b2_hi", {32'd0, word}, 64'h34);

        // stalled bus: ready 1,0,0,1,0,1,1
        set_beats(64'h0000_00a1_0000_00a0, 64'h0000_00a3_0000_00a2,
                  64'h0000_00a5_0000_00a4, 64'h0000_00a7_0000_00a6);
        fetch(64'h8000_0100, 16'h0069, 7, lat, word);
        pin("stall_latency", lat, 64'd8);
        pin("stall_word", {32'd0, word}, 64'ha0);
        for (int k = 0; k < 8; k++) fetch(64'h8000_0100 + 64'(k * 4), 16'h000f, 4, lat, word);
        fetch(64'h8000_0108, 16'h000f, 4, lat, word);
        pin("stall_b1_lo", {32'd0, word}, 64'ha2);

        // conflict on idx 0
        set_beats(64'h0000_00b1_0000_00b0, 64'h0000_00b3_0000_00b2,
                  64'h0000_00b5_0000_00b4, 64'h0000_00b7_0000_00b6);
        fetch(64'h8000_0200, 16'h000f, 4, lat, word);
        pin("evict_latency", lat, 64'd5);
        pin("evict_word", {32'd0, word}, 64'hb0);
        set_beats(64'h0000_0014_0000_0011, 64'h0000_0024_0000_0022,
                  64'h0000_0034_0000_0033, 64'h0000_0044_0000_0043);
        fetch(64'h8000_0004, 16'h000f, 4, lat, word);
        pin("refetch_latency", lat, 64'd5);
        pin("refetch_word", {32'd0, word}, 64'h14);

        // reset after two beats of a refill
        set_beats(64'h0000_00c1_0000_00c0, 64'h0000_00c3_0000_00c2,
                  64'h0000_00c5_0000_00c4, 64'h0000_00c7_0000_00c6);
        ireq_valid = 1'b1;
        ireq_addr  = 64'h8000_0040;
        idle_exp();
        @(negedge clk);
        @(posedge clk); #1;
        for (int c = 0; c < 2; c++) begin
            cresp_ready = 1'b1;
            cresp_data  = 64'h0000_00ee_0000_00e0 + 64'(c);
            exp_cv = 1'b1;
            exp_ca = 64'h8000_0040;
            @(negedge clk);
            @(posedge clk); #1;
        end
        cresp_ready = 1'b0;
        chk_en = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ireq_valid = 1'b0;
        m_clear();
        idle_exp();
        chk_en = 1'b1;
        @(negedge clk);
        pin("midrst_creq_valid", {63'd0, creq_valid}, 64'd0);
        @(posedge clk); #1;
        fetch(64'h8000_0040, 16'h000f, 4, lat, word);
        pin("midrst_latency", lat, 64'd5);
        pin("midrst_word", {32'd0, word}, 64'hc0);
        fetch(64'h8000_005c, 16'h000f, 4, lat, word);
        pin("midrst_b3_hi", {32'd0, word}, 64'hc7);
        fetch(64'h8000_0000, 16'h000f, 4, lat, word);
        pin("after_rst_miss", lat, 64'd5);

`ifdef ICACHE_FLUSH_EN
        // flush in idle: the same-cycle hit still answers, then both lines miss
        flush = 1'b1;
        fetch(64'h8000_0044, 16'h000f, 4, lat, word);
        flush = 1'b0;
        m_clear();
        pin("flush_hit_latency", lat, 64'd0);
        pin("flush_hit_word", {32'd0, word}, 64'hc1);
        fetch(64'h8000_0000, 16'h000f, 4, lat, word);
        pin("flush_miss_a", lat, 64'd5);
        fetch(64'h8000_0040, 16'h000f, 4, lat, word);
        pin("flush_miss_b", lat, 64'd5);
`endif

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
